// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: ALU operation codes, opcodes,
// branch encoding and instruction field bit positions.
package alu_pkg;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;
  localparam logic [2:0] ALU_SHL = 3'b011;
  localparam logic [2:0] ALU_SHR = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Opcodes
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_SUBI  = 4'b0010;
  localparam logic [3:0] OP_ANDI  = 4'b0011;
  localparam logic [3:0] OP_ORI   = 4'b0100;
  localparam logic [3:0] OP_SLTI  = 4'b0101;
  localparam logic [3:0] OP_LW    = 4'b0110;
  localparam logic [3:0] OP_SW    = 4'b0111;
  localparam logic [3:0] OP_BEQ   = 4'b1000;
  localparam logic [3:0] OP_BNE   = 4'b1001;
  localparam logic [3:0] OP_SLLI  = 4'b1010;
  localparam logic [3:0] OP_SRLI  = 4'b1011;

  // Branch encoding
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;

  // Instruction field bit positions
  localparam int unsigned OP_MSB    = 15;
  localparam int unsigned OP_LSB    = 12;
  localparam int unsigned RS_MSB    = 11;
  localparam int unsigned RS_LSB    = 9;
  localparam int unsigned RT_MSB    = 8;
  localparam int unsigned RT_LSB    = 6;
  localparam int unsigned RD_MSB    = 5;
  localparam int unsigned RD_LSB    = 3;
  localparam int unsigned FUNCT_MSB = 2;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_MSB   = 5;
  localparam int unsigned IMM_LSB   = 0;

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decoder.
// Ports:
//   instr_i      instruction word
//   alu_ctrl_o   ALU operation code
//   imm_sext_o   sign-extended 6-bit immediate
//   imm_b_o      immediate extended as the B operand wants it
//   b_imm_o      1: B operand is imm_b_o, 0: B operand is rt data
//   dest_o       destination register (0 when the op writes nothing)
//   reg_write_o, mem_read_o, mem_write_o, branch_o   control flags
//   rs_used_o, rt_used_o   source-register usage for hazard detection
//   illegal_o    undefined opcode
module alu_decode
  import alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       instr_i,
  output logic [2:0]        alu_ctrl_o,
  output logic [DATA_W-1:0] imm_sext_o,
  output logic [DATA_W-1:0] imm_b_o,
  output logic              b_imm_o,
  output logic [2:0]        dest_o,
  output logic              reg_write_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [1:0]        branch_o,
  output logic              rs_used_o,
  output logic              rt_used_o,
  output logic              illegal_o
);

  logic [3:0]        op;
  logic [2:0]        rt;
  logic [2:0]        rd;
  logic [2:0]        funct;
  logic [5:0]        imm;
  logic [DATA_W-1:0] imm_zext;

  assign op    = instr_i[OP_MSB:OP_LSB];
  assign rt    = instr_i[RT_MSB:RT_LSB];
  assign rd    = instr_i[RD_MSB:RD_LSB];
  assign funct = instr_i[FUNCT_MSB:FUNCT_LSB];
  assign imm   = instr_i[IMM_MSB:IMM_LSB];

  assign imm_sext_o = {{(DATA_W-6){imm[5]}}, imm};
  assign imm_zext   = {{(DATA_W-6){1'b0}}, imm};

  always_comb begin
    alu_ctrl_o  = ALU_ADD;
    imm_b_o     = imm_sext_o;
    b_imm_o     = 1'b1;
    dest_o      = rt;
    reg_write_o = 1'b1;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    branch_o    = BR_NONE;
    rs_used_o   = 1'b1;
    rt_used_o   = 1'b0;
    illegal_o   = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        alu_ctrl_o = funct;
        b_imm_o    = 1'b0;
        dest_o     = rd;
        rt_used_o  = 1'b1;
      end
      OP_ADDI: alu_ctrl_o = ALU_ADD;
      OP_SUBI: alu_ctrl_o = ALU_SUB;
      OP_ANDI: begin
        alu_ctrl_o = ALU_AND;
        imm_b_o    = imm_zext;
      end
      OP_ORI: begin
        alu_ctrl_o = ALU_OR;
        imm_b_o    = imm_zext;
      end
      OP_SLTI: alu_ctrl_o = ALU_SLT;
      OP_SLLI: begin
        alu_ctrl_o = ALU_SHL;
        imm_b_o    = imm_zext;
      end
      OP_SRLI: begin
        alu_ctrl_o = ALU_SHR;
        imm_b_o    = imm_zext;
      end
      OP_LW: mem_read_o = 1'b1;
      OP_SW: begin
        mem_write_o = 1'b1;
        reg_write_o = 1'b0;
        dest_o      = '0;
        rt_used_o   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        alu_ctrl_o  = ALU_SUB;
        b_imm_o     = 1'b0;
        reg_write_o = 1'b0;
        dest_o      = '0;
        rt_used_o   = 1'b1;
        branch_o    = (op == OP_BEQ) ? BR_BEQ : BR_BNE;
      end
      default: begin
        illegal_o   = 1'b1;
        b_imm_o     = 1'b0;
        reg_write_o = 1'b0;
        dest_o      = '0;
        rs_used_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the 16-bit ALU: decodes the ID instruction,
// detects load-use hazards, and holds the result in the ID/EX register with
// stall/flush control. Also counts issued instructions and bubbles.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_valid, id_instr, id_ready  instruction handshake (id_ready combinational)
//   id_rs_addr, id_rt_addr        register-file read addresses
//   rs_data, rt_data              register-file read data
//   ex_stall, ex_flush            downstream hold / kill
//   ex_*                          ID/EX register outputs
//   issue_count, bubble_count     performance counters
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [15:0]       id_instr,
  output logic              id_ready,
  output logic [2:0]        id_rs_addr,
  output logic [2:0]        id_rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              ex_stall,
  input  logic              ex_flush,
  output logic              ex_valid,
  output logic [2:0]        ex_alu_control,
  output logic [DATA_W-1:0] ex_input_A,
  output logic [DATA_W-1:0] ex_input_B,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [2:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [1:0]        ex_branch,
  output logic              ex_illegal,
  output logic [CNT_W-1:0]  issue_count,
  output logic [CNT_W-1:0]  bubble_count
);

  logic [2:0]        dec_alu;
  logic [DATA_W-1:0] dec_imm_sext;
  logic [DATA_W-1:0] dec_imm_b;
  logic              dec_b_imm;
  logic [2:0]        dec_dest;
  logic              dec_rw, dec_mr, dec_mw, dec_rs_used, dec_rt_used, dec_ill;
  logic [1:0]        dec_br;
  logic              hazard;

  logic              valid_q, valid_d;
  logic [2:0]        alu_q, alu_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, store_q, store_d, imm_q, imm_d;
  logic [2:0]        rd_q, rd_d;
  logic              rw_q, rw_d, mr_q, mr_d, mw_q, mw_d, ill_q, ill_d;
  logic [1:0]        br_q, br_d;
  logic [CNT_W-1:0]  issue_q, issue_d, bubble_q, bubble_d;

  alu_decode #(.DATA_W(DATA_W)) u_decode (
    .instr_i     (id_instr),
    .alu_ctrl_o  (dec_alu),
    .imm_sext_o  (dec_imm_sext),
    .imm_b_o     (dec_imm_b),
    .b_imm_o     (dec_b_imm),
    .dest_o      (dec_dest),
    .reg_write_o (dec_rw),
    .mem_read_o  (dec_mr),
    .mem_write_o (dec_mw),
    .branch_o    (dec_br),
    .rs_used_o   (dec_rs_used),
    .rt_used_o   (dec_rt_used),
    .illegal_o   (dec_ill)
  );

  assign id_rs_addr = id_instr[RS_MSB:RS_LSB];
  assign id_rt_addr = id_instr[RT_MSB:RT_LSB];

  // Hazard looks only at registered EX state, so the bubble itself clears it.
  assign hazard = valid_q & mr_q & (rd_q != '0) & id_valid &
                  ((dec_rs_used & (id_rs_addr == rd_q)) |
                   (dec_rt_used & (id_rt_addr == rd_q)));

  assign id_ready = ex_flush | (~ex_stall & ~hazard & id_valid);

  always_comb begin
    valid_d  = valid_q;
    alu_d    = alu_q;
    a_d      = a_q;
    b_d      = b_q;
    store_d  = store_q;
    imm_d    = imm_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    mr_d     = mr_q;
    mw_d     = mw_q;
    br_d     = br_q;
    ill_d    = ill_q;
    issue_d  = issue_q;
    bubble_d = bubble_q;
    if (!ex_stall || ex_flush) begin
      // Flush, bubble and idle all leave an empty, control-free EX slot.
      valid_d = 1'b0;
      alu_d   = '0;
      a_d     = '0;
      b_d     = '0;
      store_d = '0;
      imm_d   = '0;
      rd_d    = '0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      br_d    = BR_NONE;
      ill_d   = 1'b0;
      if (!ex_flush) begin
        if (hazard) begin
          bubble_d = bubble_q + CNT_W'(1);
        end else if (id_valid) begin
          valid_d = 1'b1;
          alu_d   = dec_alu;
          a_d     = rs_data;
          b_d     = dec_b_imm ? dec_imm_b : rt_data;
          store_d = rt_data;
          imm_d   = dec_imm_sext;
          rd_d    = dec_dest;
          rw_d    = dec_rw & (dec_dest != '0);
          mr_d    = dec_mr;
          mw_d    = dec_mw;
          br_d    = dec_br;
          ill_d   = dec_ill;
          issue_d = issue_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      alu_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      store_q  <= '0;
      imm_q    <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      br_q     <= '0;
      ill_q    <= 1'b0;
      issue_q  <= '0;
      bubble_q <= '0;
    end else begin
      valid_q  <= valid_d;
      alu_q    <= alu_d;
      a_q      <= a_d;
      b_q      <= b_d;
      store_q  <= store_d;
      imm_q    <= imm_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      br_q     <= br_d;
      ill_q    <= ill_d;
      issue_q  <= issue_d;
      bubble_q <= bubble_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_alu_control = alu_q;
  assign ex_input_A     = a_q;
  assign ex_input_B     = b_q;
  assign ex_store_data  = store_q;
  assign ex_imm         = imm_q;
  assign ex_rd          = rd_q;
  assign ex_reg_write   = rw_q;
  assign ex_mem_read    = mr_q;
  assign ex_mem_write   = mw_q;
  assign ex_branch      = br_q;
  assign ex_illegal     = ill_q;
  assign issue_count    = issue_q;
  assign bubble_count   = bubble_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [15:0] id_instr;
  logic        id_ready;
  logic [2:0]  id_rs_addr, id_rt_addr;
  logic [15:0] rs_data, rt_data;
  logic        ex_stall, ex_flush;
  logic        ex_valid;
  logic [2:0]  ex_alu_control;
  logic [15:0] ex_input_A, ex_input_B, ex_store_data, ex_imm;
  logic [2:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [1:0]  ex_branch;
  logic        ex_illegal;
  logic [15:0] issue_count, bubble_count;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  alu_issue_stage #(.DATA_W(16), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_ready       (id_ready),
    .id_rs_addr     (id_rs_addr),
    .id_rt_addr     (id_rt_addr),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .ex_stall       (ex_stall),
    .ex_flush       (ex_flush),
    .ex_valid       (ex_valid),
    .ex_alu_control (ex_alu_control),
    .ex_input_A     (ex_input_A),
    .ex_input_B     (ex_input_B),
    .ex_store_data  (ex_store_data),
    .ex_imm         (ex_imm),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_branch      (ex_branch),
    .ex_illegal     (ex_illegal),
    .issue_count    (issue_count),
    .bubble_count   (bubble_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, ex_valid, 0);
    chk({tag, ".rw"}, ex_reg_write, 0);
    chk({tag, ".mr"}, ex_mem_read, 0);
    chk({tag, ".mw"}, ex_mem_write, 0);
    chk({tag, ".br"}, ex_branch, 0);
    chk({tag, ".ill"}, ex_illegal, 0);
  endtask

  task automatic chk_cnt(input string tag, input int unsigned iss, input int unsigned bub);
    chk({tag, ".issue"}, issue_count, iss);
    chk({tag, ".bubble"}, bubble_count, bub);
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_instr = '0;
    rs_data = '0; rt_data = '0; ex_stall = 1'b0; ex_flush = 1'b0;
    tick();
    tick();
    // Reset state
    chk_idle("rst");
    chk("rst.alu", ex_alu_control, 0);
    chk("rst.A", ex_input_A, 0);
    chk("rst.B", ex_input_B, 0);
    chk("rst.rd", ex_rd, 0);
    chk_cnt("rst", 0, 0);
    chk("rst.rdy0", id_ready, 0);
    id_valid = 1'b1; #1;
    chk("rst.rdy1", id_ready, 1);
    rst = 1'b0;

    // ADDI r2 = r1 + (-3)
    id_instr = 16'h12BD; rs_data = 16'd10; rt_data = 16'h0055; #1;
    chk("addi.rsaddr", id_rs_addr, 1);
    chk("addi.rtaddr", id_rt_addr, 2);
    chk("addi.rdy", id_ready, 1);
    tick();
    chk("addi.valid", ex_valid, 1);
    chk("addi.alu", ex_alu_control, 0);
    chk("addi.A", ex_input_A, 16'd10);
    chk("addi.B", ex_input_B, 16'hFFFD);
    chk("addi.imm", ex_imm, 16'hFFFD);
    chk("addi.rd", ex_rd, 2);
    chk("addi.rw", ex_reg_write, 1);
    chk("addi.mr", ex_mem_read, 0);
    chk_cnt("addi", 1, 0);

    // ANDI imm 0x3F: zero-extended B, sign-extended ex_imm
    id_instr = 16'h32FF; rs_data = 16'd7;
    tick();
    chk("andi.alu", ex_alu_control, 3'b101);
    chk("andi.B", ex_input_B, 16'h003F);
    chk("andi.imm", ex_imm, 16'hFFFF);
    chk("andi.rd", ex_rd, 3);

    // SLTI imm 0x3F: sign-extended B
    id_instr = 16'h52FF;
    tick();
    chk("slti.alu", ex_alu_control, 3'b111);
    chk("slti.B", ex_input_B, 16'hFFFF);
    chk_cnt("slti", 3, 0);

    // LW r3, 4(r1)
    id_instr = 16'h62C4; rs_data = 16'd100;
    tick();
    chk("lw.valid", ex_valid, 1);
    chk("lw.mr", ex_mem_read, 1);
    chk("lw.rd", ex_rd, 3);
    chk("lw.rw", ex_reg_write, 1);
    chk("lw.B", ex_input_B, 16'd4);

    // ADD r4 = r5 + r3 -> load-use on rt
    id_instr = 16'h0AE0; rs_data = 16'd5; rt_data = 16'd9; #1;
    chk("haz.rdy", id_ready, 0);
    tick();
    chk_idle("bubble");
    chk_cnt("bubble", 4, 1);
    chk("bubble.rdy", id_ready, 1);
    tick();
    chk("add.valid", ex_valid, 1);
    chk("add.alu", ex_alu_control, 0);
    chk("add.A", ex_input_A, 16'd5);
    chk("add.B", ex_input_B, 16'd9);
    chk("add.rd", ex_rd, 4);
    chk("add.rw", ex_reg_write, 1);
    chk_cnt("add", 5, 1);

    // Stall 3 cycles with SUB r6 = r1 - r2 waiting
    id_instr = 16'h02B1; rs_data = 16'd20; rt_data = 16'd3; ex_stall = 1'b1; #1;
    chk("stall.rdy", id_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.valid", ex_valid, 1);
      chk("stall.alu", ex_alu_control, 0);
      chk("stall.A", ex_input_A, 16'd5);
      chk("stall.rd", ex_rd, 4);
      chk_cnt("stall", 5, 1);
    end
    ex_stall = 1'b0;
    tick();
    chk("sub.alu", ex_alu_control, 3'b001);
    chk("sub.A", ex_input_A, 16'd20);
    chk("sub.B", ex_input_B, 16'd3);
    chk("sub.rd", ex_rd, 6);
    chk_cnt("sub", 6, 1);

    // Flush and stall together: flush wins
    ex_stall = 1'b1; ex_flush = 1'b1; #1;
    chk("flush.rdy", id_ready, 1);
    tick();
    chk_idle("flush");
    chk_cnt("flush", 6, 1);
    ex_stall = 1'b0; ex_flush = 1'b0;

    // Undefined opcode 1111
    id_instr = 16'hF2C8;
    tick();
    chk("ill.valid", ex_valid, 1);
    chk("ill.ill", ex_illegal, 1);
    chk("ill.rw", ex_reg_write, 0);
    chk("ill.mr", ex_mem_read, 0);
    chk("ill.mw", ex_mem_write, 0);
    chk("ill.br", ex_branch, 0);

    // ADDI writing r0
    id_instr = 16'h1201;
    tick();
    chk("r0.valid", ex_valid, 1);
    chk("r0.rw", ex_reg_write, 0);
    chk("r0.ill", ex_illegal, 0);

    // SW rt=r2, offset 2
    id_instr = 16'h7282; rt_data = 16'hBEEF; rs_data = 16'h0100;
    tick();
    chk("sw.mw", ex_mem_write, 1);
    chk("sw.store", ex_store_data, 16'hBEEF);
    chk("sw.rw", ex_reg_write, 0);
    chk("sw.B", ex_input_B, 16'd2);

    // BNE offset -2
    id_instr = 16'h92BE; rt_data = 16'h1234;
    tick();
    chk("bne.br", ex_branch, 2'b10);
    chk("bne.alu", ex_alu_control, 3'b001);
    chk("bne.B", ex_input_B, 16'h1234);
    chk("bne.imm", ex_imm, 16'hFFFE);
    chk_cnt("bne", 10, 1);

    // Stall during hazard: EX held, bubble not counted until stall drops
    id_instr = 16'h62C4;
    tick();
    id_instr = 16'h0AE0; ex_stall = 1'b1;
    tick();
    chk("hstall.valid", ex_valid, 1);
    chk("hstall.mr", ex_mem_read, 1);
    chk_cnt("hstall", 11, 1);
    ex_stall = 1'b0;
    tick();
    chk_idle("hbub");
    chk_cnt("hbub", 11, 2);
    tick();
    chk("hadd.rd", ex_rd, 4);
    chk_cnt("hadd", 12, 2);

    // LW r3 then ADDI whose rt is r3: rt is not a source, no bubble
    id_instr = 16'h62C4;
    tick();
    id_instr = 16'h12C1; #1;
    chk("nohaz.rdy", id_ready, 1);
    tick();
    chk("nohaz.valid", ex_valid, 1);
    chk_cnt("nohaz", 14, 2);

    // Idle
    id_valid = 1'b0;
    tick();
    chk_idle("idle");

    // Reset while stalled
    id_valid = 1'b1; id_instr = 16'h12BD;
    tick();
    rst = 1'b1; ex_stall = 1'b1;
    tick();
    chk_idle("rst2");
    chk_cnt("rst2", 0, 0);
    chk("rst2.A", ex_input_A, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
